traffic_phase_ctrl: RTL and testbench

- Phase sequencer for a two-way intersection (north-south / east-west) with pedestrian and night-flash support.
- Consumes the 1-second tick produced by the second counter (its last pulse) and steps the vehicle lights through timed phases.
- Owns the per-phase countdown and exposes it for the display path.

---
 rtl/traffic_phase_ctrl.sv | 171 +++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer with pedestrian service and night flash.
// Advances on the 1 s tick; owns the per-phase countdown shown on the display.
module traffic_phase_ctrl #(
  parameter int pGREEN_NS = 20,
  parameter int pGREEN_EW = 15,
  parameter int pYELLOW   = 3,
  parameter int pALL_RED  = 2,
  parameter int pWALK     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       ped_walk,
  output logic [2:0] phase,
  output logic [6:0] remain,
  output logic       phase_end
);

  typedef enum logic [2:0] {
    ALL_RED_A = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALL_RED_B = 3'd3,
    PED_WALK  = 3'd4,
    EW_GREEN  = 3'd5,
    EW_YELLOW = 3'd6,
    FLASH     = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Countdown load value (duration minus one) for a state being entered
  function automatic logic [6:0] dur_m1(input state_t s);
    logic [6:0] d;
    case (s)
      ALL_RED_A, ALL_RED_B: d = 7'(pALL_RED - 1);
      NS_GREEN:             d = 7'(pGREEN_NS - 1);
      NS_YELLOW, EW_YELLOW: d = 7'(pYELLOW - 1);
      PED_WALK:             d = 7'(pWALK - 1);
      EW_GREEN:             d = 7'(pGREEN_EW - 1);
      default:              d = 7'd0;
    endcase
    return d;
  endfunction

  state_t     phase_r, phase_s, succ_s;
  logic [6:0] remain_r, remain_s;
  logic       flash_on_r, flash_on_s;
  logic       ped_pending_r, ped_pending_s;
  logic       phase_end_r, phase_end_s;
  logic       ped_walk_r, ped_walk_s;
  logic [2:0] light_ns_r, light_ns_s;
  logic [2:0] light_ew_r, light_ew_s;
  logic       step_s;

  assign step_s = en & tick;

  // Next-state, countdown, pedestrian latch and lamp decode
  always_comb begin
    phase_s       = phase_r;
    remain_s      = remain_r;
    flash_on_s    = flash_on_r;
    ped_pending_s = ped_pending_r;
    phase_end_s   = 1'b0;
    light_ns_s    = LAMP_R;
    light_ew_s    = LAMP_R;
    ped_walk_s    = 1'b0;

    case (phase_r)
      ALL_RED_A: succ_s = NS_GREEN;
      NS_GREEN:  succ_s = NS_YELLOW;
      NS_YELLOW: succ_s = ALL_RED_B;
      ALL_RED_B: succ_s = ped_pending_r ? PED_WALK : EW_GREEN;
      PED_WALK:  succ_s = EW_GREEN;
      EW_GREEN:  succ_s = EW_YELLOW;
      default:   succ_s = ALL_RED_A;
    endcase

    if (step_s) begin
      if (phase_r == FLASH) begin
        // Leaving night operation wins over another flash toggle
        if (night_mode) begin
          flash_on_s = ~flash_on_r;
        end else begin
          phase_s     = ALL_RED_A;
          remain_s    = dur_m1(ALL_RED_A);
          flash_on_s  = 1'b0;
          phase_end_s = 1'b1;
        end
      end else if (remain_r == 7'd0) begin
        phase_end_s = 1'b1;
        if (night_mode) begin
          phase_s    = FLASH;
          remain_s   = 7'd0;
          flash_on_s = 1'b1;
        end else begin
          phase_s  = succ_s;
          remain_s = dur_m1(succ_s);
        end
      end else begin
        remain_s = remain_r - 7'd1;
      end
    end else begin
      remain_s = remain_r;
    end

    // A request coinciding with walk entry or flash entry is absorbed
    if (phase_end_s && (phase_s == PED_WALK || phase_s == FLASH)) begin
      ped_pending_s = 1'b0;
    end else if (ped_req && phase_r != PED_WALK) begin
      ped_pending_s = 1'b1;
    end else begin
      ped_pending_s = ped_pending_r;
    end

    case (phase_s)
      NS_GREEN:  light_ns_s = LAMP_G;
      NS_YELLOW: light_ns_s = LAMP_Y;
      EW_GREEN:  light_ew_s = LAMP_G;
      EW_YELLOW: light_ew_s = LAMP_Y;
      PED_WALK:  ped_walk_s = 1'b1;
      FLASH: begin
        light_ns_s = flash_on_s ? LAMP_Y : LAMP_OFF;
        light_ew_s = flash_on_s ? LAMP_Y : LAMP_OFF;
      end
      default: begin
        light_ns_s = LAMP_R;
        light_ew_s = LAMP_R;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r       <= ALL_RED_A;
      remain_r      <= 7'(pALL_RED - 1);
      flash_on_r    <= 1'b0;
      ped_pending_r <= 1'b0;
      phase_end_r   <= 1'b0;
      ped_walk_r    <= 1'b0;
      light_ns_r    <= LAMP_R;
      light_ew_r    <= LAMP_R;
    end else begin
      phase_r       <= phase_s;
      remain_r      <= remain_s;
      flash_on_r    <= flash_on_s;
      ped_pending_r <= ped_pending_s;
      phase_end_r   <= phase_end_s;
      ped_walk_r    <= ped_walk_s;
      light_ns_r    <= light_ns_s;
      light_ew_r    <= light_ew_s;
    end
  end

  assign phase     = phase_r;
  assign remain    = remain_r;
  assign phase_end = phase_end_r;
  assign ped_walk  = ped_walk_r;
  assign light_ns  = light_ns_r;
  assign light_ew  = light_ew_r;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: default cycle, pedestrian, night flash,
// enable freeze, async reset and night-over-pedestrian precedence.
module tb_traffic_phase_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       tick;
  logic       ped_req;
  logic       night_mode;
  logic [2:0] light_ns;
  logic [2:0] light_ew;
  logic       ped_walk;
  logic [2:0] phase;
  logic [6:0] remain;
  logic       phase_end;

  int n_cmp = 0;
  int n_err = 0;
  int pe_cnt = 0;

  traffic_phase_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .tick       (tick),
    .ped_req    (ped_req),
    .night_mode (night_mode),
    .light_ns   (light_ns),
    .light_ew   (light_ew),
    .ped_walk   (ped_walk),
    .phase      (phase),
    .remain     (remain),
    .phase_end  (phase_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count phase_end pulses as seen by the next rising edge
  always @(posedge clk) begin
    if (rst_n && phase_end === 1'b1) pe_cnt <= pe_cnt + 1;
  end

  // Both directions may never show green/yellow together outside flash
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_cmp++;
      assert (!((light_ns[1:0] != 2'b00) && (light_ew[1:0] != 2'b00) && (phase != 3'd7)))
      else begin
        n_err++;
        $error("FAIL safety observed ns=%b ew=%b phase=%0d expected no conflicting lamps",
               light_ns, light_ew, phase);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One tick every 10 clocks; returns at the falling edge right after the sampling edge
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (9) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] ph, input logic [6:0] rm);
    check({tag, "_phase"}, 32'(phase), 32'(ph));
    check({tag, "_remain"}, 32'(remain), 32'(rm));
  endtask

  task automatic check_lamps(input string tag, input logic [2:0] ns, input logic [2:0] ew);
    check({tag, "_ns"}, 32'(light_ns), 32'(ns));
    check({tag, "_ew"}, 32'(light_ew), 32'(ew));
  endtask

  int pe_base;

  initial begin
    rst_n = 1'b0; en = 1'b0; tick = 1'b0; ped_req = 1'b0; night_mode = 1'b0;
    #12;
    check_state("rst", 3'd0, 7'd1);
    check_lamps("rst", 3'b100, 3'b100);
    check("rst_walk", 32'(ped_walk), 32'd0);
    check("rst_pe", 32'(phase_end), 32'd0);

    // Default cycle: 0,1,2,3,5,6,0 lasting 2,20,3,2,15,3 ticks
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    pe_base = pe_cnt;
    ticks(1);  check_state("c1_ar", 3'd0, 7'd0);
    ticks(1);  check_state("c1_nsg", 3'd1, 7'd19);
    check_lamps("c1_nsg", 3'b001, 3'b100);
    check("c1_pe_hi", 32'(phase_end), 32'd1);
    @(negedge clk);
    check("c1_pe_lo", 32'(phase_end), 32'd0);
    ticks(19); check_state("c1_nsg_end", 3'd1, 7'd0);
    ticks(1);  check_state("c1_nsy", 3'd2, 7'd2);
    check_lamps("c1_nsy", 3'b010, 3'b100);
    ticks(3);  check_state("c1_arb", 3'd3, 7'd1);
    check_lamps("c1_arb", 3'b100, 3'b100);
    ticks(2);  check_state("c1_ewg", 3'd5, 7'd14);
    check_lamps("c1_ewg", 3'b100, 3'b001);
    ticks(15); check_state("c1_ewy", 3'd6, 7'd2);
    check_lamps("c1_ewy", 3'b100, 3'b010);
    ticks(3);  check_state("c1_wrap", 3'd0, 7'd1);
    @(negedge clk);
    check("c1_pe_count", 32'(pe_cnt - pe_base), 32'd6);

    // Pedestrian request during NS green is served after ALL_RED_B
    ticks(2);  check_state("p_nsg", 3'd1, 7'd19);
    @(negedge clk); ped_req = 1'b1;
    @(negedge clk); ped_req = 1'b0;
    ticks(20); ticks(3);
    check_state("p_arb", 3'd3, 7'd1);
    ticks(2);  check_state("p_walk", 3'd4, 7'd7);
    check("p_walk_out", 32'(ped_walk), 32'd1);
    check_lamps("p_walk", 3'b100, 3'b100);
    ticks(7);  check_state("p_walk_end", 3'd4, 7'd0);
    ticks(1);  check_state("p_ewg", 3'd5, 7'd14);
    check("p_walk_off", 32'(ped_walk), 32'd0);
    ticks(18); check_state("p_wrap", 3'd0, 7'd1);
    ticks(27); check_state("p_skip", 3'd5, 7'd14);

    // Night flash entered at the end of NS green
    ticks(20); check_state("n_nsg", 3'd1, 7'd19);
    night_mode = 1'b1;
    ticks(19); check_state("n_nsg_end", 3'd1, 7'd0);
    ticks(1);  check_state("n_flash", 3'd7, 7'd0);
    check_lamps("n_on1", 3'b010, 3'b010);
    check("n_pe", 32'(phase_end), 32'd1);
    ticks(1);  check_lamps("n_off", 3'b000, 3'b000);
    ticks(1);  check_lamps("n_on2", 3'b010, 3'b010);
    night_mode = 1'b0;
    ticks(1);  check_state("n_exit", 3'd0, 7'd1);
    check_lamps("n_exit", 3'b100, 3'b100);
    check("n_exit_pe", 32'(phase_end), 32'd1);

    // Enable low freezes the countdown while ticks continue
    ticks(27); ticks(7);
    check_state("e_pre", 3'd5, 7'd7);
    en = 1'b0;
    ticks(5);  check_state("e_frozen", 3'd5, 7'd7);
    en = 1'b1;
    ticks(6);  check_state("e_rem1", 3'd5, 7'd1);
    ticks(1);  check_state("e_rem0", 3'd5, 7'd0);
    ticks(1);  check_state("e_ewy", 3'd6, 7'd2);

    // Async reset between clock edges drops a pending request
    @(negedge clk); ped_req = 1'b1;
    @(negedge clk); ped_req = 1'b0;
    ticks(1);  check_state("r_pre", 3'd6, 7'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_state("r_async", 3'd0, 7'd1);
    check_lamps("r_async", 3'b100, 3'b100);
    #1 rst_n = 1'b1;
    ticks(27); check_state("r_nowalk", 3'd5, 7'd14);

    // Night request together with a pedestrian request: night wins, request dropped
    ticks(43); check_state("s_arb", 3'd3, 7'd1);
    @(negedge clk); ped_req = 1'b1; night_mode = 1'b1;
    @(negedge clk); ped_req = 1'b0;
    ticks(1);  check_state("s_arb0", 3'd3, 7'd0);
    ticks(1);  check_state("s_flash", 3'd7, 7'd0);
    night_mode = 1'b0;
    ticks(1);  check_state("s_exit", 3'd0, 7'd1);
    ticks(27); check_state("s_nowalk", 3'd5, 7'd14);
    check("s_walk_off", 32'(ped_walk), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
